// File: rtl/alu_operand_issue.sv
// RV32I operand issue stage: decodes one instruction into ALU operands and select
// code, and holds it in a single registered slot with valid/ready handshaking.
module alu_operand_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        flush,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [3:0]  out_sel,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_illegal
);

  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_ADD  = 4'b0010;
  localparam logic [3:0] SEL_SLL  = 4'b0011;
  localparam logic [3:0] SEL_SLT  = 4'b0100;
  localparam logic [3:0] SEL_SLTU = 4'b0101;
  localparam logic [3:0] SEL_SUB  = 4'b0110;
  localparam logic [3:0] SEL_XOR  = 4'b0111;
  localparam logic [3:0] SEL_SRL  = 4'b1000;
  localparam logic [3:0] SEL_SRA  = 4'b1010;
  localparam logic [3:0] SEL_PASB = 4'b1111;

  // Opcodes are matched on instr[6:2]; the two low bits are deliberately ignored.
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [4:0]  opc;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic        unused_low_bits;

  assign opc    = in_instr[6:2];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rd     = in_instr[11:7];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign shamt  = {27'b0, in_instr[24:20]};
  assign unused_low_bits = ^in_instr[1:0];

  logic [3:0]  dec_sel;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        dec_rw;
  logic        dec_ill;
  logic [3:0]  base_sel;

  // Shared funct3 -> select mapping for the register and immediate ALU forms.
  always_comb begin
    base_sel = SEL_ADD;
    case (funct3)
      3'b000:  base_sel = SEL_ADD;
      3'b001:  base_sel = SEL_SLL;
      3'b010:  base_sel = SEL_SLT;
      3'b011:  base_sel = SEL_SLTU;
      3'b100:  base_sel = SEL_XOR;
      3'b101:  base_sel = SEL_SRL;
      3'b110:  base_sel = SEL_OR;
      default: base_sel = SEL_AND;
    endcase
  end

  always_comb begin
    dec_sel = SEL_ADD;
    dec_a   = 32'b0;
    dec_b   = 32'b0;
    dec_rw  = 1'b0;
    dec_ill = 1'b0;
    case (opc)
      OPC_OP: begin
        dec_a  = in_rs1_data;
        dec_b  = in_rs2_data;
        dec_rw = 1'b1;
        if (funct7 == F7_BASE) begin
          dec_sel = base_sel;
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_sel = SEL_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_sel = SEL_SRA;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec_a   = in_rs1_data;
        dec_b   = imm_i;
        dec_rw  = 1'b1;
        dec_sel = base_sel;
        if (funct3 == 3'b001) begin
          dec_b = shamt;
          if (funct7 != F7_BASE) dec_ill = 1'b1;
        end else if (funct3 == 3'b101) begin
          dec_b = shamt;
          if (funct7 == F7_ALT) dec_sel = SEL_SRA;
          else if (funct7 != F7_BASE) dec_ill = 1'b1;
        end
      end
      OPC_LOAD: begin
        dec_a  = in_rs1_data;
        dec_b  = imm_i;
        dec_rw = 1'b1;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) dec_ill = 1'b1;
      end
      OPC_STORE: begin
        dec_a = in_rs1_data;
        dec_b = imm_s;
        if (funct3 > 3'b010) dec_ill = 1'b1;
      end
      OPC_BRANCH: begin
        dec_a = in_rs1_data;
        dec_b = in_rs2_data;
        case (funct3)
          3'b000, 3'b001: dec_sel = SEL_SUB;
          3'b100, 3'b101: dec_sel = SEL_SLT;
          3'b110, 3'b111: dec_sel = SEL_SLTU;
          default:        dec_ill = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec_sel = SEL_PASB;
        dec_b   = imm_u;
        dec_rw  = 1'b1;
      end
      OPC_AUIPC: begin
        dec_a  = in_pc;
        dec_b  = imm_u;
        dec_rw = 1'b1;
      end
      OPC_JAL: begin
        dec_a  = in_pc;
        dec_b  = 32'd4;
        dec_rw = 1'b1;
      end
      OPC_JALR: begin
        dec_a  = in_pc;
        dec_b  = 32'd4;
        dec_rw = 1'b1;
        if (funct3 != 3'b000) dec_ill = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
    // Illegal slots carry neutral operands so execute sees a harmless add.
    if (dec_ill) begin
      dec_sel = SEL_ADD;
      dec_a   = 32'b0;
      dec_b   = 32'b0;
      dec_rw  = 1'b0;
    end
    if (rd == 5'd0) dec_rw = 1'b0;
  end

  logic        valid_q, valid_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  sel_q, sel_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic        ill_q, ill_d;
  logic        capture;

  assign in_ready = (!valid_q || out_ready) && !rst;
  assign capture  = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    ill_d   = ill_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      a_d     = dec_a;
      b_d     = dec_b;
      sel_d   = dec_sel;
      rd_d    = rd;
      rw_d    = dec_rw;
      ill_d   = dec_ill;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= 32'b0;
      b_q     <= 32'b0;
      sel_q   <= SEL_ADD;
      rd_q    <= 5'b0;
      rw_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_a         = a_q;
  assign out_b         = b_q;
  assign out_sel       = sel_q;
  assign out_rd        = rd_q;
  assign out_reg_write = rw_q;
  assign out_illegal   = ill_q;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed-vector bench for alu_operand_issue with hand-computed expectations.
module tb_alu_operand_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_sel;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_illegal;

  int tests  = 0;
  int errors = 0;

  alu_operand_issue dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .in_rs1_data   (in_rs1_data),
    .in_rs2_data   (in_rs2_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .flush         (flush),
    .out_a         (out_a),
    .out_b         (out_b),
    .out_sel       (out_sel),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write),
    .out_illegal   (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_slot(input string tag, input logic v, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] sel, input logic [4:0] rd,
                            input logic rw, input logic ill);
    check({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
    check({tag, ".a"}, out_a, a);
    check({tag, ".b"}, out_b, b);
    check({tag, ".sel"}, {28'b0, out_sel}, {28'b0, sel});
    check({tag, ".rd"}, {27'b0, out_rd}, {27'b0, rd});
    check({tag, ".rw"}, {31'b0, out_reg_write}, {31'b0, rw});
    check({tag, ".ill"}, {31'b0, out_illegal}, {31'b0, ill});
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid    = 1'b1;
    in_instr    = instr;
    in_pc       = pc;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'b0; in_pc = 32'b0;
    in_rs1_data = 32'b0; in_rs2_data = 32'b0; out_ready = 1'b1; flush = 1'b0;
    tick();
    tick();
    check_slot("reset", 1'b0, 32'h0, 32'h0, 4'b0010, 5'd0, 1'b0, 1'b0);
    check("reset.in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_reset.in_ready", {31'b0, in_ready}, 32'd1);

    issue(32'hFFF08293, 32'h100, 32'h10, 32'h99);
    check_slot("addi", 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0010, 5'd5, 1'b1, 1'b0);

    issue(32'h402081B3, 32'h104, 32'h20, 32'h5);
    check_slot("sub", 1'b1, 32'h20, 32'h5, 4'b0110, 5'd3, 1'b1, 1'b0);
    issue(32'h4030D093, 32'h108, 32'h80, 32'h5);
    check_slot("srai", 1'b1, 32'h80, 32'h3, 4'b1010, 5'd1, 1'b1, 1'b0);

    issue(32'h123453B7, 32'h10C, 32'hDEAD, 32'hBEEF);
    check_slot("lui", 1'b1, 32'h0, 32'h12345000, 4'b1111, 5'd7, 1'b1, 1'b0);

    issue(32'hFFF08290, 32'h110, 32'h10, 32'h0);
    check_slot("addi_lowbits", 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0010, 5'd5, 1'b1, 1'b0);

    issue(32'h0020A423, 32'h114, 32'h1000, 32'h77);
    check_slot("sw", 1'b1, 32'h1000, 32'h8, 4'b0010, 5'd8, 1'b0, 1'b0);

    issue(32'h0020E063, 32'h118, 32'h3, 32'h9);
    check_slot("bltu", 1'b1, 32'h3, 32'h9, 4'b0101, 5'd0, 1'b0, 1'b0);

    issue(32'h000000EF, 32'h200, 32'h1, 32'h2);
    check_slot("jal", 1'b1, 32'h200, 32'h4, 4'b0010, 5'd1, 1'b1, 1'b0);

    issue(32'h00001117, 32'h300, 32'h1, 32'h2);
    check_slot("auipc", 1'b1, 32'h300, 32'h1000, 4'b0010, 5'd2, 1'b1, 1'b0);

    issue(32'h00208033, 32'h304, 32'h5, 32'h6);
    check_slot("add_x0", 1'b1, 32'h5, 32'h6, 4'b0010, 5'd0, 1'b0, 1'b0);

    issue(32'h02208233, 32'h308, 32'h5, 32'h6);
    check_slot("op_bad_f7", 1'b1, 32'h0, 32'h0, 4'b0010, 5'd4, 1'b0, 1'b1);

    issue(32'h0000037F, 32'h30C, 32'h5, 32'h6);
    check_slot("opc_7f", 1'b1, 32'h0, 32'h0, 4'b0010, 5'd6, 1'b0, 1'b1);

    in_valid = 1'b0;
    tick();
    check_slot("retire", 1'b0, 32'h0, 32'h0, 4'b0010, 5'd6, 1'b0, 1'b1);

    issue(32'h00208233, 32'h400, 32'h11, 32'h22);
    check_slot("stall_head", 1'b1, 32'h11, 32'h22, 4'b0010, 5'd4, 1'b1, 1'b0);
    out_ready   = 1'b0;
    in_instr    = 32'h0020C333;
    in_rs1_data = 32'h33;
    in_rs2_data = 32'h44;
    #1;
    check("stall.in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_slot("stall_hold", 1'b1, 32'h11, 32'h22, 4'b0010, 5'd4, 1'b1, 1'b0);
      check("stall_hold.in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("unstall.in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check_slot("unstall_xor", 1'b1, 32'h33, 32'h44, 4'b0111, 5'd6, 1'b1, 1'b0);

    flush    = 1'b1;
    in_instr = 32'hFFF08293;
    #1;
    check("flush.in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("flush.valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0;

    issue(32'h00208233, 32'h500, 32'h55, 32'h66);
    check_slot("pre_rst", 1'b1, 32'h55, 32'h66, 4'b0010, 5'd4, 1'b1, 1'b0);
    out_ready = 1'b0;
    tick();
    check("pre_rst_stall.valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    tick();
    check_slot("mid_stall_rst", 1'b0, 32'h0, 32'h0, 4'b0010, 5'd0, 1'b0, 1'b0);
    check("mid_stall_rst.in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("after_rst.in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check_slot("after_rst_cap", 1'b1, 32'h55, 32'h66, 4'b0010, 5'd4, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
